// File: rtl/axisrng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axisrng_pkg
//  Description : Shared state encoding and helper for the random-word scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package axisrng_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BURST = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    // A single requester still needs a 1-bit index field.
    function automatic int f_idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axisrng_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : axisrng_sched_if
//  Description : Upstream and downstream AXI-stream signals of the scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface axisrng_sched_if #(
    parameter int C_AXIS_DATA_WIDTH = 32,
    parameter int LGNREQ            = 2
) ();
    logic                         S_AXIS_TVALID;
    logic                         S_AXIS_TREADY;
    logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic                         M_AXIS_TVALID;
    logic                         M_AXIS_TREADY;
    logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA;
    logic                         M_AXIS_TLAST;
    logic [LGNREQ-1:0]            M_AXIS_TDEST;

    // Scheduler side: consumes the source stream, drives the shared output.
    modport master (
        input  S_AXIS_TVALID, S_AXIS_TDATA, M_AXIS_TREADY,
        output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TDEST
    );

    modport slave (
        output S_AXIS_TVALID, S_AXIS_TDATA, M_AXIS_TREADY,
        input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TDEST
    );
endinterface
`default_nettype wire

// File: rtl/axisrng_rrarb.sv
`default_nettype none
// ============================================================================
//  Module      : axisrng_rrarb
//  Description : Combinational round-robin pick, searching upward from ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module axisrng_rrarb
    import axisrng_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int LGNREQ = f_idx_width(NREQ)
) (
    input  wire  [NREQ-1:0]   req,
    input  wire  [LGNREQ-1:0] ptr,
    output logic [NREQ-1:0]   grant,
    output logic [LGNREQ-1:0] index,
    output logic              any
);

    logic [LGNREQ-1:0] w_k;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        w_k   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = LGNREQ'((int'(ptr) + i) % NREQ);
            if (!any && req[w_k]) begin
                any        = 1'b1;
                index      = w_k;
                grant[w_k] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axisrng_sched.sv
`default_nettype none
// ============================================================================
//  Module      : axisrng_sched
//  Description : Round-robin burst scheduler sharing one random-word stream.
//  Revision    : 1.0  initial release
// ============================================================================
module axisrng_sched
    import axisrng_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 32,
    parameter int NREQ              = 4,
    parameter int LGNREQ            = f_idx_width(NREQ),
    parameter int LGLEN             = 8
) (
    input  wire                     S_AXI_ACLK,
    input  wire                     S_AXI_ARESETN,
    input  wire  [NREQ-1:0]         i_req,
    input  wire  [NREQ*LGLEN-1:0]   i_len,
    output logic [NREQ-1:0]         o_grant,
    output logic                    o_busy,
    axisrng_sched_if.master         axis
);

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_nxt;
    logic [LGNREQ-1:0]            r_ptr;
    logic [LGLEN-1:0]             r_cnt;
    logic                         r_m_valid;
    logic                         r_m_last;
    logic [C_AXIS_DATA_WIDTH-1:0] r_m_data;
    logic [LGNREQ-1:0]            r_m_dest;

    logic [NREQ-1:0]              w_pick_grant;
    logic [LGNREQ-1:0]            w_pick_idx;
    logic                         w_pick_any;
    logic [LGLEN-1:0]             w_len [NREQ];
    logic                         w_s_ready;
    logic                         w_s_xfer;
    logic                         w_m_xfer;

    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign w_len[g] = i_len[g*LGLEN +: LGLEN];
    end

    axisrng_rrarb #(
        .NREQ   (NREQ),
        .LGNREQ (LGNREQ)
    ) u_arb (
        .req   (i_req),
        .ptr   (r_ptr),
        .grant (w_pick_grant),
        .index (w_pick_idx),
        .any   (w_pick_any)
    );

    assign w_s_xfer = w_s_ready && axis.S_AXIS_TVALID;
    assign w_m_xfer = r_m_valid && axis.M_AXIS_TREADY;

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_pick_any) w_state_nxt = c_BURST;
            end
            c_BURST: begin
                w_s_ready = !r_m_valid || axis.M_AXIS_TREADY;
                if (w_s_ready && axis.S_AXIS_TVALID && (r_cnt == '0))
                    w_state_nxt = c_FLUSH;
            end
            c_FLUSH: begin
                if (r_m_valid && axis.M_AXIS_TREADY) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= c_IDLE;
        else                r_state <= w_state_nxt;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            o_grant   <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_m_dest  <= '0;
        end else begin
            if ((r_state == c_IDLE) && w_pick_any) begin
                o_grant  <= w_pick_grant;
                r_cnt    <= w_len[w_pick_idx];
                r_m_dest <= w_pick_idx;
            end

            if (w_s_xfer) begin
                r_m_data  <= axis.S_AXIS_TDATA;
                r_m_valid <= 1'b1;
                r_m_last  <= (r_cnt == '0);
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end else if (w_m_xfer) begin
                r_m_valid <= 1'b0;
                // Draining the final word releases the grant and advances the pointer.
                if (r_state == c_FLUSH) begin
                    r_m_last <= 1'b0;
                    o_grant  <= '0;
                    r_ptr    <= (r_m_dest == LGNREQ'(NREQ - 1)) ? '0 : r_m_dest + 1'b1;
                end
            end
        end
    end

    assign o_busy             = (r_state != c_IDLE);
    assign axis.S_AXIS_TREADY = w_s_ready;
    assign axis.M_AXIS_TVALID = r_m_valid;
    assign axis.M_AXIS_TDATA  = r_m_data;
    assign axis.M_AXIS_TLAST  = r_m_last;
    assign axis.M_AXIS_TDEST  = r_m_dest;

endmodule
`default_nettype wire

// File: tb/tb_axisrng_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axisrng_sched
//  Description : Scoreboard bench for the round-robin random-word scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axisrng_sched;

    localparam int DW     = 32;
    localparam int NREQ   = 4;
    localparam int LGNREQ = 2;
    localparam int LGLEN  = 8;

    typedef struct packed {
        logic [DW-1:0]     d;
        logic              l;
        logic [LGNREQ-1:0] dst;
    } exp_t;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   i_req;
    logic [NREQ*LGLEN-1:0] i_len;
    logic [NREQ-1:0]   o_grant;
    logic              o_busy;

    exp_t              sb[$];
    int                hs_cyc[$];
    int                errors = 0;
    int                checks = 0;
    int                cyc    = 0;
    int                nout   = 0;
    bit                mon_en = 1'b1;
    logic [DW-1:0]     src_data = '0;

    axisrng_sched_if #(.C_AXIS_DATA_WIDTH(DW), .LGNREQ(LGNREQ)) bus ();

    axisrng_sched #(
        .C_AXIS_DATA_WIDTH (DW),
        .NREQ              (NREQ),
        .LGNREQ            (LGNREQ),
        .LGLEN             (LGLEN)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .i_req         (i_req),
        .i_len         (i_len),
        .o_grant       (o_grant),
        .o_busy        (o_busy),
        .axis          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [DW-1:0] v);
        src_data = v;
    endtask

    task automatic push_burst(input logic [DW-1:0] base, input int n, input logic [LGNREQ-1:0] dst);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d   = base + DW'(i);
            e.l   = (i == n - 1);
            e.dst = dst;
            sb.push_back(e);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grant"}, 32'(o_grant), 32'h0);
        chk({tag, "_busy"},  32'(o_busy), 32'h0);
        chk({tag, "_sready"}, 32'(bus.S_AXIS_TREADY), 32'h0);
        chk({tag, "_mvalid"}, 32'(bus.M_AXIS_TVALID), 32'h0);
        chk({tag, "_mlast"},  32'(bus.M_AXIS_TLAST), 32'h0);
        chk({tag, "_mdest"},  32'(bus.M_AXIS_TDEST), 32'h0);
        chk({tag, "_mdata"},  bus.M_AXIS_TDATA, 32'h0);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || o_busy) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words pending, required 0 within %0d cycles", tag, sb.size(), budget);
        end
    endtask

    // Upstream source: a counter that advances on every accepted word.
    initial begin
        logic hs;
        bus.S_AXIS_TDATA = '0;
        forever begin
            @(negedge clk);
            hs = bus.S_AXIS_TVALID && bus.S_AXIS_TREADY && rst_n;
            @(posedge clk);
            #1;
            if (hs) src_data = src_data + 1;
            bus.S_AXIS_TDATA = src_data;
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        logic          p_stall;
        logic [DW-1:0] p_data;
        logic          p_last;
        logic [LGNREQ-1:0] p_dest;
        exp_t          e;
        p_stall = 1'b0;
        p_data  = '0;
        p_last  = 1'b0;
        p_dest  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY) begin
                    chk("stall_sready", 32'(bus.S_AXIS_TREADY), 32'h0);
                    if (p_stall) begin
                        chk("stall_data", bus.M_AXIS_TDATA, p_data);
                        chk("stall_last", 32'(bus.M_AXIS_TLAST), 32'(p_last));
                        chk("stall_dest", 32'(bus.M_AXIS_TDEST), 32'(p_dest));
                    end
                end
                if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
                    nout++;
                    hs_cyc.push_back(cyc);
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected: got data=%0h last=%0b dest=%0d, required no word",
                                 bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, bus.M_AXIS_TDEST);
                    end else begin
                        e = sb.pop_front();
                        if (bus.M_AXIS_TDATA !== e.d || bus.M_AXIS_TLAST !== e.l || bus.M_AXIS_TDEST !== e.dst) begin
                            errors++;
                            $display("FAIL out_word: got data=%0h last=%0b dest=%0d, required data=%0h last=%0b dest=%0d",
                                     bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, bus.M_AXIS_TDEST, e.d, e.l, e.dst);
                        end
                    end
                end
            end
            p_stall = rst_n && bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
            p_data  = bus.M_AXIS_TDATA;
            p_last  = bus.M_AXIS_TLAST;
            p_dest  = bus.M_AXIS_TDEST;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] gseq [5];
        logic [NREQ-1:0] prev_g;
        logic [7:0]      pat;
        int              ng;
        int              n0;

        i_req = '0;
        i_len = '0;
        bus.S_AXIS_TVALID = 1'b0;
        bus.M_AXIS_TREADY = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single request from requester 1, four words.
        set_src(32'hA0);
        bus.S_AXIS_TVALID = 1'b1;
        i_len[1*LGLEN +: LGLEN] = 8'd3;
        i_req = 4'b0010;
        tick();
        chk("t1_grant", 32'(o_grant), 32'h2);
        chk("t1_busy", 32'(o_busy), 32'h1);
        chk("t1_sready", 32'(bus.S_AXIS_TREADY), 32'h1);
        chk("t1_valid_n1", 32'(bus.M_AXIS_TVALID), 32'h0);
        push_burst(32'hA0, 4, 2'd1);
        i_req = '0;
        tick();
        chk("t1_valid_n2", 32'(bus.M_AXIS_TVALID), 32'h1);
        wait_drain("t1", 50);

        // All requesting, length 0: rotation 0,1,2,3,0 from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        hs_cyc.delete();
        set_src(32'hB0);
        i_len = '0;
        gseq[0] = 4'b0001; gseq[1] = 4'b0010; gseq[2] = 4'b0100; gseq[3] = 4'b1000; gseq[4] = 4'b0001;
        for (int k = 0; k < 5; k++) push_burst(32'hB0 + 32'(k), 1, LGNREQ'(k % 4));
        i_req = 4'b1111;
        prev_g = '0;
        ng = 0;
        for (int k = 0; k < 40 && ng < 5; k++) begin
            tick();
            if (prev_g == '0 && o_grant != '0) begin
                chk("t2_grant_seq", 32'(o_grant), 32'(gseq[ng]));
                ng++;
            end
            prev_g = o_grant;
        end
        i_req = '0;
        chk("t2_grant_count", 32'(ng), 32'd5);
        wait_drain("t2", 50);
        chk("t2_words", 32'(hs_cyc.size()), 32'd5);
        if (hs_cyc.size() == 5)
            for (int k = 1; k < 5; k++) chk("t2_gap", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd3);

        // Output backpressure on a three-word burst.
        set_src(32'hC0);
        i_len[2*LGLEN +: LGLEN] = 8'd2;
        i_req = 4'b0100;
        n0 = nout;
        tick();
        chk("t3_grant", 32'(o_grant), 32'h4);
        i_req = '0;
        push_burst(32'hC0, 3, 2'd2);
        pat = 8'b1111_0011;
        for (int k = 0; k < 8; k++) begin
            bus.M_AXIS_TREADY = pat[k];
            tick();
        end
        bus.M_AXIS_TREADY = 1'b1;
        wait_drain("t3", 50);
        chk("t3_words", 32'(nout - n0), 32'd3);

        // Asynchronous reset in the middle of an eight-word burst.
        mon_en = 1'b0;
        set_src(32'h200);
        i_len[1*LGLEN +: LGLEN] = 8'd7;
        i_req = 4'b0010;
        tick();
        i_req = '0;
        tick();
        tick();
        chk("t6_midburst_valid", 32'(bus.M_AXIS_TVALID), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("t6_async");
        sb.delete();
        i_len = '0;
        i_len[0*LGLEN +: LGLEN] = 8'd1;
        i_req = 4'b1001;
        tick();
        set_src(32'h300);
        tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        chk("t6_ptr0_grant", 32'(o_grant), 32'h1);
        i_req = '0;
        push_burst(32'h300, 2, 2'd0);
        wait_drain("t6a", 50);
        set_src(32'h310);
        i_req = 4'b1000;
        tick();
        chk("t6_grant3", 32'(o_grant), 32'h8);
        chk("t6_dest3", 32'(bus.M_AXIS_TDEST), 32'h3);
        i_req = '0;
        push_burst(32'h310, 1, 2'd3);
        wait_drain("t6b", 50);

        // Upstream starvation mid-burst.
        set_src(32'hD0);
        i_len[0*LGLEN +: LGLEN] = 8'd5;
        i_req = 4'b0001;
        n0 = nout;
        tick();
        i_req = '0;
        push_burst(32'hD0, 6, 2'd0);
        tick();
        tick();
        bus.S_AXIS_TVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k >= 1) begin
                chk("t4_no_valid", 32'(bus.M_AXIS_TVALID), 32'h0);
                chk("t4_hold_grant", 32'(o_grant), 32'h1);
            end
        end
        bus.S_AXIS_TVALID = 1'b1;
        wait_drain("t4", 50);
        chk("t4_words", 32'(nout - n0), 32'd6);

        // Mid-burst changes to i_req / i_len are ignored: 256 words.
        set_src(32'h1000);
        i_len[3*LGLEN +: LGLEN] = 8'd255;
        i_req = 4'b1000;
        n0 = nout;
        tick();
        chk("t5_grant", 32'(o_grant), 32'h8);
        push_burst(32'h1000, 256, 2'd3);
        repeat (10) tick();
        i_req = '0;
        i_len = 32'h0505_0505;
        wait_drain("t5", 400);
        chk("t5_words", 32'(nout - n0), 32'd256);
        chk("t5_idle", 32'(o_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
